gpr_writeback: RTL
==================

# gpr_writeback

Write-side front end for the general-purpose register file. It accepts writeback results from the ALU and the load/store unit over valid/ready handshakes and queues them in order in a small FIFO. It drains one entry per cycle onto the register file's single write port (`wbe`/`rdn`/`rdd`). It also forwards queued-but-not-yet-written values to the decode stage, so reads never see stale register contents.

## Interface
- `WordSize`, 32: data width of every result and forwarded value.
- `Depth`, 4: write-queue entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  WordSize  ALU result.
- `lsu_valid`  in  1  load result available.
- `lsu_ready`  out  1  load result accepted this cycle.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  WordSize  load result.
- `wbe`  out  1  register-file write enable.
- `rdn`  out  5  register-file write address.
- `rdd`  out  WordSize  register-file write data.
- `rs1n`, `rs2n`  in  5 each  decode-stage read addresses.
- `fwd1_hit`, `fwd2_hit`  out  1 each  queued value overrides the register-file read.
- `fwd1_data`, `fwd2_data`  out  WordSize each  forwarded value.
- `empty`  out  1  queue empty; used by the pipeline for drain/fence.

## Operation
- Queue: circular buffer of `Depth` entries {rd, data}. It has a head pointer, a tail pointer, and a count of width clog2(Depth+1). The pointers wrap modulo `Depth`.
- Arbitration: fixed priority, LSU over ALU. At most one enqueue per cycle.
  - `lsu_ready = !full`.
  - `alu_ready = !full && !lsu_valid`.
- Handshake: a transfer occurs when valid && ready at the rising edge. The source holds rd/data stable while valid && !ready.
- x0 writes: a transfer with rd == 0 completes the handshake normally but is discarded and not enqueued.
- Drain: while the queue is non-empty, `wbe = 1` and `rdn`/`rdd` = head entry, combinationally. The head pops at every rising edge where `wbe` = 1. No backpressure from the register file.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: ready stays low while count == `Depth`, even if a pop occurs that cycle. There is no pass-through.
- Forwarding: for each read port, scan the valid entries from youngest to oldest. The first entry with a matching rd wins: hit = 1, data = that entry.
  - rs == 0 never hits.
  - The head entry being written this cycle still forwards, because the register file updates only at the edge.
  - An entry being enqueued this cycle does not forward.
- `empty = (count == 0)`.
- Reset (`rst` = 1 at an edge): count and pointers are cleared. In-flight and queued entries are dropped. Entry storage is not cleared.

## Timing
- Reset values: `wbe` = 0, `rdn` = 0, `rdd` = 0 (gated to 0 when empty), `alu_ready` = 1 iff `!lsu_valid`, `lsu_ready` = 1, fwd hits = 0, fwd data = 0, `empty` = 1.
- Latency: a result accepted at edge N appears on `wbe`/`rdn`/`rdd` during cycle N+1 at the earliest, and is written to the register file at edge N+1. Each older queued entry adds one cycle.
- Forward visibility: from cycle N+1 until the entry is written at its pop edge.
- Throughput: one result per cycle sustained, so the queue never fills with a single active source.
- Reset mid-operation: the next cycle shows `empty` = 1 and `wbe` = 0. Pending writes are lost by design; the pipeline flushes alongside.

## Configuration
- `GPR_WB_FORWARD_EN` defined: the forwarding comparators and muxes are built as described.
- Undefined: no comparators are built, and `fwd1_hit`, `fwd2_hit`, `fwd1_data`, `fwd2_data` are tied to 0. Decode must stall on `!empty` before reading any register.

## Test plan
- Single ALU write: `alu_valid` = 1, rd = 5, data = 0xDEADBEEF for one cycle → next cycle `wbe` = 1, `rdn` = 5, `rdd` = 0xDEADBEEF; the cycle after, `empty` = 1.
- Priority: `lsu_valid` and `alu_valid` both asserted, rd = 3 / 4 → `lsu_ready` = 1, `alu_ready` = 0. The LSU entry (rd 3) drains first and the ALU entry (rd 4) one cycle later.
- x0 discard: ALU rd = 0, data = 0x1234 → `alu_ready` = 1, `wbe` stays 0, `empty` stays 1.
- Full boundary (`Depth` = 4), modelled as a queue that is not draining: fill 4 entries → both readies low. One pop → readies high the next cycle. No entry is lost or duplicated across 100 random pushes versus the reference order.
- Forwarding (macro defined): enqueue rd = 7 with 0x11, then rd = 7 with 0x22; `rs1n` = 7 → `fwd1_hit` = 1, `fwd1_data` = 0x22. `rs2n` = 0 → `fwd2_hit` = 0.
- Reset mid-drain: 3 entries queued, `rst` = 1 for one edge → next cycle `wbe` = 0, `empty` = 1, all fwd hits 0.

Source files
------------

// File: rtl/gpr_writeback.sv
// In-order writeback queue in front of the GPR file write port, with optional
// decode-stage forwarding of queued results (enabled by GPR_WB_FORWARD_EN).
`timescale 1ns/1ps

module gpr_writeback #(
  parameter int WordSize = 32,
  parameter int Depth    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [4:0]          alu_rd,
  input  logic [WordSize-1:0] alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [4:0]          lsu_rd,
  input  logic [WordSize-1:0] lsu_data,
  output logic                wbe,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] rdd,
  input  logic [4:0]          rs1n,
  input  logic [4:0]          rs2n,
  output logic                fwd1_hit,
  output logic                fwd2_hit,
  output logic [WordSize-1:0] fwd1_data,
  output logic [WordSize-1:0] fwd2_data,
  output logic                empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [4:0]          ent_rd_q   [Depth];
  logic [WordSize-1:0] ent_data_q [Depth];
  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;

  logic                full;
  logic                push_fire;
  logic                push_en;
  logic                pop;
  logic [4:0]          push_rd;
  logic [WordSize-1:0] push_data;

  assign full      = (count_q == CntW'(Depth));
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;

  // Only one source can be granted per cycle, so the mux select is simply lsu_valid.
  assign push_fire = (lsu_valid && lsu_ready) || (alu_valid && alu_ready);
  assign push_rd   = lsu_valid ? lsu_rd   : alu_rd;
  assign push_data = lsu_valid ? lsu_data : alu_data;
  assign push_en   = push_fire && (push_rd != 5'd0);

  assign pop   = (count_q != '0);
  assign empty = !pop;
  assign wbe   = pop;
  assign rdn   = pop ? ent_rd_q[head_q]   : 5'd0;
  assign rdd   = pop ? ent_data_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_en) begin
      tail_d = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left out of reset; count_q alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ent_rd_q[tail_q]   <= push_rd;
      ent_data_q[tail_q] <= push_data;
    end
  end

`ifdef GPR_WB_FORWARD_EN
  logic [4:0] rs_n [2];
  assign rs_n[0] = rs1n;
  assign rs_n[1] = rs2n;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic                hit;
    logic [WordSize-1:0] data;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int k = 0; k < Depth; k++) begin
        if ((CntW'(k) < count_q) && (rs_n[gi] != 5'd0) &&
            (ent_rd_q[head_q + PtrW'(k)] == rs_n[gi])) begin
          hit  = 1'b1;
          data = ent_data_q[head_q + PtrW'(k)];
        end
      end
    end
  end

  assign fwd1_hit  = g_fwd[0].hit;
  assign fwd1_data = g_fwd[0].data;
  assign fwd2_hit  = g_fwd[1].hit;
  assign fwd2_data = g_fwd[1].data;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1n, rs2n};

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
